mu0_mem_arbiter: RTL
====================

# mu0_mem_arbiter

Two-master arbiter that shares the single-port, one-cycle-read-latency MU0 memory between the CPU (master 0) and a loader/DMA port (master 1). Each master sees a waitrequest-style bus. The arbiter serialises accesses through a small FSM, drives the memory address and strobes from latched copies, and returns read data to the owning master. It sits between the CPU/loader and the memory model in the top-level.

## Interface
Parameters:
- ADDR_W, 12, address width (MU0 word address)
- DATA_W, 16, data width
- FIXED_PRIORITY, 0, 0 = round-robin between masters; 1 = master 0 always wins contention

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  master 0 word address
- m0_read, m0_write  in  1 each  master 0 strobes
- m0_writedata  in  DATA_W  master 0 write data
- m0_readdata  out  DATA_W  master 0 read data, valid only in its read-completion cycle
- m0_waitrequest  out  1  low only in the cycle master 0's transaction completes
- m1_*  same set as m0_*, for master 1
- mem_address  out  ADDR_W  to memory
- mem_read, mem_write  out  1 each  to memory
- mem_writedata  out  DATA_W  to memory
- mem_readdata  in  DATA_W  from memory; valid one cycle after mem_read with the address held
- busy  out  1  FSM not in IDLE
- protocol_error  out  1  sticky; set when a master asserts read and write together

## Operation
- Master protocol:
  - A master asserts read or write and holds address, strobes and writedata stable while its waitrequest is 1.
  - The transaction completes in the single cycle that waitrequest is 0.
  - Read data is valid on mX_readdata in that same cycle.
- FSM states are IDLE, ISSUE and READ_DATA.
- IDLE:
  - If no master requests, stay in IDLE.
  - Otherwise pick the owner:
    - Only one master requesting: that master.
    - Both requesting, FIXED_PRIORITY=1: master 0.
    - Both requesting, round-robin: the master that is not `last`.
  - Latch owner, address, writedata and op (write wins if both strobes are set; protocol_error is set), then go to ISSUE.
- ISSUE:
  - Drive mem_address and mem_writedata from the latches.
  - Drive mem_write for a write, mem_read for a read.
  - Write: owner waitrequest=0 this cycle; `last` <= owner; next state IDLE.
  - Read: next state READ_DATA, with mem_address held and mem_read=1.
- READ_DATA:
  - Owner readdata = mem_readdata, owner waitrequest=0.
  - mem_read=0, mem_address still held.
  - `last` <= owner; next state IDLE.
- The non-owner's waitrequest is always 1. readdata outputs are 0 outside the owner's READ_DATA cycle.
- Requests arriving in ISSUE or READ_DATA wait; they are evaluated on the next IDLE.
- Latched copies are used, so master bus changes after grant are ignored.

## Timing
- Reset values: state IDLE, `last`=1 (master 0 wins the first tie), owner 0, mem_address 0, mem_read/mem_write 0, mem_writedata 0. Both waitrequests 1, readdata 0, busy 0, protocol_error 0.
- Write latency: request seen in IDLE at cycle N, memory write and completion at N+1. Throughput is one write per 2 cycles.
- Read latency: request at N, mem_read at N+1, data and completion at N+2. Throughput is one read per 3 cycles.
- A master's completion cycle always precedes a return to IDLE, so a still-asserted strobe in the following IDLE is a new transaction.
- Round-robin: under continuous contention grants strictly alternate.
- Reset mid-operation: the FSM returns to IDLE immediately and no completion is signalled. An in-flight master must re-issue after reset. A half-written memory cycle is not retried.
- protocol_error is cleared only by rst.

## Structure
- Shared package mu0_bus_pkg:
  - state_t enum {IDLE, ISSUE, READ_DATA}
  - master_id_t (1 bit)
  - ADDR_W/DATA_W defaults
- The grant decision goes in sub-module mu0_rr_pick: combinational 2-way chooser, inputs req[1:0], last, fixed; output owner.
- FSM, latches and output muxing live in mu0_mem_arbiter.

## Test plan
- Master 0 write: m0 writes 0x1234 to 0x005 → mem_write=1, mem_address=0x005 at N+1; m0_waitrequest=0 at N+1 only; memory holds 0x1234.
- Master 1 read: mem[0x010]=0xBEEF, m1 read 0x010 → mem_read at N+1, m1_readdata=0xBEEF with m1_waitrequest=0 at N+2; m0_waitrequest stays 1.
- Round-robin contention: both masters continuously read different addresses → grants go m0, m1, m0, m1 with completions every 3 cycles. With FIXED_PRIORITY=1, m0 gets every grant.
- Request during busy: m1 requests in m0's ISSUE cycle → m1 is granted at the next IDLE and completes 2 (write) or 3 (read) cycles after it.
- Reset mid-read: assert rst in ISSUE → all waitrequests 1, mem_read 0, busy 0 immediately; m0 re-issues and completes normally.
- Protocol error: m0 asserts read and write to 0x020 with data 0x0042 → treated as a write; protocol_error=1 and stays 1 until rst.

Source files
------------

// File: rtl/mu0_bus_pkg.sv
// Shared types and default widths for the MU0 memory bus and its arbiter.
package mu0_bus_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      READ_DATA = 2'd2
   } state_t;

   typedef logic master_id_t;

endpackage

// File: rtl/mu0_rr_pick.sv
// Two-way grant chooser: single requester wins outright; on a tie either
// master 0 (fixed) or the master that did not go last (round-robin).
module mu0_rr_pick
   import mu0_bus_pkg::*;
(
   input  logic [1:0] req,
   input  master_id_t last,
   input  logic       fixed,
   output master_id_t owner
);

   // Resolve the owner from the request pair and the previous owner
   always_comb begin
      owner = 1'b0;
      case (req)
         2'b01: owner = 1'b0;
         2'b10: owner = 1'b1;
         2'b11: begin
            if (fixed) begin
               owner = 1'b0;
            end else begin
               owner = ~last;
            end
         end
         default: owner = 1'b0;
      endcase
   end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Arbiter sharing the single-port MU0 memory between the CPU (master 0) and
// the loader (master 1). Requests are latched on grant so the memory sees a
// stable address/data for the whole access; strobes and waitrequests leave
// on flops computed from the next-state decision.
module mu0_mem_arbiter
   import mu0_bus_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_waitrequest,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_waitrequest,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic              busy,
   output logic              protocol_error
);

   state_t            state_r, state_s;
   master_id_t        owner_r, owner_s, last_r, last_s, pick_s;
   logic              op_wr_r, op_wr_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [DATA_W-1:0] wdata_r, wdata_s;
   logic              perr_r, perr_s;
   logic [1:0]        req_s;
   logic              sel_rd_s, sel_wr_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;
   logic              mem_read_s, mem_write_s, done_s, m0_wait_s, m1_wait_s;
   logic              mem_read_r, mem_write_r, m0_wait_r, m1_wait_r, busy_r;

   assign req_s = {m1_read | m1_write, m0_read | m0_write};

   mu0_rr_pick u_pick (
      .req   (req_s),
      .last  (last_r),
      .fixed (FIXED_PRIORITY),
      .owner (pick_s)
   );

   // Route the bus of the master that would win a grant this cycle
   always_comb begin
      if (pick_s == 1'b1) begin
         sel_rd_s    = m1_read;
         sel_wr_s    = m1_write;
         sel_addr_s  = m1_address;
         sel_wdata_s = m1_writedata;
      end else begin
         sel_rd_s    = m0_read;
         sel_wr_s    = m0_write;
         sel_addr_s  = m0_address;
         sel_wdata_s = m0_writedata;
      end
   end

   // Next state, grant latches, round-robin history and sticky error
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      last_s  = last_r;
      op_wr_s = op_wr_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
      perr_s  = perr_r;
      case (state_r)
         IDLE: begin
            if (req_s != 2'b00) begin
               state_s = ISSUE;
               owner_s = pick_s;
               op_wr_s = sel_wr_s;   // write wins when both strobes are set
               addr_s  = sel_addr_s;
               wdata_s = sel_wdata_s;
               perr_s  = perr_r | (sel_rd_s & sel_wr_s);
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (op_wr_r) begin
               state_s = IDLE;
               last_s  = owner_r;
            end else begin
               state_s = READ_DATA;
            end
         end
         READ_DATA: begin
            state_s = IDLE;
            last_s  = owner_r;
         end
         default: state_s = IDLE;
      endcase
   end

   // Bus-facing strobes for the upcoming cycle, registered below
   always_comb begin
      mem_write_s = (state_s == ISSUE) && op_wr_s;
      mem_read_s  = (state_s == ISSUE) && !op_wr_s;
      done_s      = mem_write_s || (state_s == READ_DATA);
      m0_wait_s   = !(done_s && (owner_s == 1'b0));
      m1_wait_s   = !(done_s && (owner_s == 1'b1));
   end

   // State, latches and registered outputs; reset abandons any access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         owner_r     <= 1'b0;
         last_r      <= 1'b1;
         op_wr_r     <= 1'b0;
         addr_r      <= {ADDR_W{1'b0}};
         wdata_r     <= {DATA_W{1'b0}};
         perr_r      <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         m0_wait_r   <= 1'b1;
         m1_wait_r   <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         owner_r     <= owner_s;
         last_r      <= last_s;
         op_wr_r     <= op_wr_s;
         addr_r      <= addr_s;
         wdata_r     <= wdata_s;
         perr_r      <= perr_s;
         mem_read_r  <= mem_read_s;
         mem_write_r <= mem_write_s;
         m0_wait_r   <= m0_wait_s;
         m1_wait_r   <= m1_wait_s;
         busy_r      <= (state_s != IDLE);
      end
   end

   assign mem_address    = addr_r;
   assign mem_writedata  = wdata_r;
   assign mem_read       = mem_read_r;
   assign mem_write      = mem_write_r;
   assign m0_waitrequest = m0_wait_r;
   assign m1_waitrequest = m1_wait_r;
   assign busy           = busy_r;
   assign protocol_error = perr_r;

   // Memory data passes straight through to the owner in its completion cycle
   assign m0_readdata = ((state_r == READ_DATA) && (owner_r == 1'b0)) ? mem_readdata : {DATA_W{1'b0}};
   assign m1_readdata = ((state_r == READ_DATA) && (owner_r == 1'b1)) ? mem_readdata : {DATA_W{1'b0}};

endmodule
